conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Sequencer for the convolution core's datapath. On a start pulse it walks the two input memories (X, Y) with a nested index loop, multiply-accumulates each product pair, and writes every output sample z[i] = Σ x[k]·y[i−k] into the output memory. It sits between the AIP register/memory wrapper (start, sizes, done flag) and the X/Y/Z memories.

## Interface
- DATA_W, 16, unsigned sample width of X and Y memory words
- ADDR_W, 5, X/Y memory address width; max length per input 2^ADDR_W
- ACC_W, 2*DATA_W+ADDR_W, accumulator/Z word width (overflow-free by construction)

- clk  in  1  system clock, all logic on rising edge
- rst_a  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- size_x  in  ADDR_W+1  X length NX (0..2^ADDR_W), latched at start
- size_y  in  ADDR_W+1  Y length NY, latched at start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- x_rd  out  1  X memory read enable
- x_addr  out  ADDR_W  X read address
- x_data  in  DATA_W  X read data, valid the cycle after x_rd
- y_rd  out  1  Y memory read enable
- y_addr  out  ADDR_W  Y read address
- y_data  in  DATA_W  Y read data, valid the cycle after y_rd
- z_we  out  1  Z memory write strobe
- z_addr  out  ADDR_W+1  Z write address i
- z_data  out  ACC_W  Z write data

## Operation
- States: IDLE, SETUP, RUN, DRAIN, WRITE, DONE.
- IDLE: start=1 latches NX, NY; if NX=0 or NY=0 -> DONE (no writes), else i=0 -> SETUP.
- SETUP (1 cycle): k_lo=max(0,i−NY+1), k_hi=min(i,NX−1); k=k_lo; acc cleared to 0.
- RUN (k_hi−k_lo+1 cycles): x_rd=y_rd=1, x_addr=k, y_addr=i−k; k increments each cycle; after issuing k_hi -> DRAIN.
- Accumulate: whenever a read was issued in the previous cycle, acc <= acc + x_data*y_data (full 2*DATA_W product, zero-extended to ACC_W).
- DRAIN (1 cycle): last product accumulated; no reads.
- WRITE (1 cycle): z_we=1, z_addr=i, z_data=acc. If i=NX+NY−2 -> DONE, else i=i+1 -> SETUP.
- DONE (1 cycle): done=1 -> IDLE.
- Outside RUN: x_rd=y_rd=0, x_addr=y_addr=0. Outside WRITE: z_we=0, z_addr=0, z_data=0.
- start while busy: ignored, no effect on latched sizes or indices.
- Arithmetic is unsigned; no saturation needed (max NX·(2^DATA_W−1)^2 fits ACC_W).

## Timing
- Reset: all outputs 0, state IDLE, acc/i/k/latched sizes 0. Reset mid-run aborts immediately; no further z_we; a new start is accepted on the first edge after release.
- Per output sample: n_i+3 cycles (SETUP + n_i RUN + DRAIN + WRITE), n_i = k_hi−k_lo+1.
- Total: start sampled at edge 0 -> done high in cycle NX·NY + 3·(NX+NY−1) + 1; busy high cycles 1 through that cycle inclusive, low the cycle after.
- Zero length: done high in cycle 1, busy high only in cycle 1.
- Memory read latency fixed at 1 cycle; no back-pressure. z_we writes are never stalled.
- Z writes occur in strictly ascending z_addr order, exactly NX+NY−1 writes per run.

## Test plan
- Basic: NX=1, NY=1, x={3}, y={4} -> single write z[0]=12 in cycle 4, done in cycle 5, busy cycles 1–5.
- Typical: NX=3, NY=2, x={1,2,3}, y={1,1} -> writes z={1,3,5,3} at addresses 0..3, done in cycle 19.
- Max size/width: NX=NY=32, all samples 0xFFFF -> 63 writes, z[31]=32·0xFFFE0001, done in cycle 1024+189+1=1214, no overflow.
- Zero length: NX=0, NY=5 start -> no z_we, no x_rd/y_rd, done in cycle 1.
- Start while busy: second start pulse with different sizes mid-run of the 3×2 case -> results and timing identical to the single-run case.
- Reset mid-run: assert rst_a during RUN of the 3×2 case -> all outputs 0 same cycle, IDLE; new start afterward produces full correct z={1,3,5,3}.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks X/Y memories with a nested index loop,
// multiply-accumulates each product pair and writes z[i] to the Z memory.
module conv_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 2*DATA_W+ADDR_W
) (
    input  logic                clk,
    input  logic                rst_a,
    input  logic                start,
    input  logic [ADDR_W:0]     size_x,
    input  logic [ADDR_W:0]     size_y,
    output logic                busy,
    output logic                done,
    output logic                x_rd,
    output logic [ADDR_W-1:0]   x_addr,
    input  logic [DATA_W-1:0]   x_data,
    output logic                y_rd,
    output logic [ADDR_W-1:0]   y_addr,
    input  logic [DATA_W-1:0]   y_data,
    output logic                z_we,
    output logic [ADDR_W:0]     z_addr,
    output logic [ACC_W-1:0]    z_data
);
    localparam int SW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       nx_q, nx_d, ny_q, ny_d;
    logic [SW-1:0]       i_q, i_d, k_q, k_d, k_hi_q, k_hi_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                rd_q, rd_d;

    logic [2*DATA_W-1:0] prod;
    logic [SW-1:0]       i_inc;
    logic [SW:0]         i_last;

    assign prod   = x_data * y_data;
    assign i_inc  = i_q + SW'(1);
    assign i_last = {1'b0, nx_q} + {1'b0, ny_q} - (SW+1)'(2);

    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        i_d     = i_q;
        k_d     = k_q;
        k_hi_d  = k_hi_q;
        rd_d    = 1'b0;
        acc_d   = acc_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        x_rd    = 1'b0;
        y_rd    = 1'b0;
        x_addr  = '0;
        y_addr  = '0;
        z_we    = 1'b0;
        z_addr  = '0;
        z_data  = '0;

        // Read data arrives one cycle after the read, so accumulation lags RUN by one.
        if (rd_q) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nx_d = size_x;
                    ny_d = size_y;
                    i_d  = '0;
                    if (size_x == '0 || size_y == '0) state_d = S_DONE;
                    else                              state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                k_d    = (i_inc > ny_q) ? (i_inc - ny_q) : '0;
                k_hi_d = (i_q < nx_q - SW'(1)) ? i_q : (nx_q - SW'(1));
                acc_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                x_rd   = 1'b1;
                y_rd   = 1'b1;
                x_addr = ADDR_W'(k_q);
                y_addr = ADDR_W'(i_q - k_q);
                rd_d   = 1'b1;
                if (k_q == k_hi_q) state_d = S_DRAIN;
                else               k_d = k_q + SW'(1);
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                z_we   = 1'b1;
                z_addr = i_q;
                z_data = acc_q;
                if ({1'b0, i_q} == i_last) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_inc;
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q <= S_IDLE;
            nx_q    <= '0;
            ny_q    <= '0;
            i_q     <= '0;
            k_q     <= '0;
            k_hi_q  <= '0;
            acc_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            i_q     <= i_d;
            k_q     <= k_d;
            k_hi_q  <= k_hi_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: directed runs push expected Z writes and
// done cycles into queues; a negedge monitor pops and compares.
module tb_conv_seq_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int ACC_W  = 2*DATA_W+ADDR_W;

    logic              clk = 1'b0;
    logic              rst_a;
    logic              start;
    logic [ADDR_W:0]   size_x, size_y;
    logic              busy, done;
    logic              x_rd, y_rd, z_we;
    logic [ADDR_W-1:0] x_addr, y_addr;
    logic [DATA_W-1:0] x_data, y_data;
    logic [ADDR_W:0]   z_addr;
    logic [ACC_W-1:0]  z_data;

    conv_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_a(rst_a), .start(start), .size_x(size_x), .size_y(size_y),
        .busy(busy), .done(done), .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .y_rd(y_rd), .y_addr(y_addr), .y_data(y_data),
        .z_we(z_we), .z_addr(z_addr), .z_data(z_data)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] x_mem [32];
    logic [DATA_W-1:0] y_mem [32];
    always @(posedge clk) begin
        if (x_rd) x_data <= x_mem[x_addr];
        if (y_rd) y_data <= y_mem[y_addr];
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W:0]  a;
        logic [ACC_W-1:0] d;
    } zexp_t;

    zexp_t      zq[$];
    longint     dq[$];
    zexp_t      e_m;
    longint     d_m;
    logic [ACC_W-1:0] exp_z [64];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_a) begin
            if (z_we) begin
                chk("zwe_expected", 64'(zq.size() != 0), 64'd1);
                if (zq.size() != 0) begin
                    e_m = zq.pop_front();
                    chk("z_addr", 64'(z_addr), 64'(e_m.a));
                    chk("z_data", 64'(z_data), 64'(e_m.d));
                end
            end
            if (done) begin
                chk("done_expected", 64'(dq.size() != 0), 64'd1);
                if (dq.size() != 0) begin
                    d_m = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(d_m));
                    chk("writes_left_at_done", 64'(zq.size()), 64'd0);
                    chk("busy_at_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    // Call right after a negedge; start is sampled on the following posedge (edge 0).
    task automatic issue(input int nx, input int ny, input int nz, input longint nd);
        size_x = (ADDR_W+1)'(nx);
        size_y = (ADDR_W+1)'(ny);
        start  = 1'b1;
        for (int i = 0; i < nz; i++) zq.push_back('{a: (ADDR_W+1)'(i), d: exp_z[i]});
        dq.push_back(cyc + nd);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000; n++) begin
            if (done) break;
            @(negedge clk);
        end
        chk("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_after_done", 64'(done), 64'd0);
    endtask

    task automatic load_3x2();
        x_mem[0] = 16'd1; x_mem[1] = 16'd2; x_mem[2] = 16'd3;
        y_mem[0] = 16'd1; y_mem[1] = 16'd1;
        exp_z[0] = 37'd1; exp_z[1] = 37'd3; exp_z[2] = 37'd5; exp_z[3] = 37'd3;
    endtask

    initial begin
        rst_a = 1'b1; start = 1'b0; size_x = '0; size_y = '0;
        for (int i = 0; i < 32; i++) begin x_mem[i] = '0; y_mem[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd", 64'({x_rd, y_rd}), 64'd0);
        chk("rst_addr", 64'({x_addr, y_addr}), 64'd0);
        chk("rst_zwe", 64'(z_we), 64'd0);
        chk("rst_zaddr_data", 64'({z_addr, z_data}), 64'd0);
        rst_a = 1'b0;
        @(negedge clk);

        // Basic 1x1
        x_mem[0] = 16'd3; y_mem[0] = 16'd4; exp_z[0] = 37'd12;
        issue(1, 1, 1, 5);
        chk("basic_busy_c1", 64'(busy), 64'd1);
        wait_done();

        // Typical 3x2
        load_3x2();
        @(negedge clk);
        issue(3, 2, 4, 19);
        wait_done();

        // Zero length: done in cycle 1, no reads
        @(negedge clk);
        issue(0, 5, 0, 1);
        chk("zero_busy_c1", 64'(busy), 64'd1);
        chk("zero_no_reads", 64'({x_rd, y_rd}), 64'd0);
        wait_done();

        // Start while busy is ignored
        @(negedge clk);
        issue(3, 2, 4, 19);
        repeat (4) @(negedge clk);
        size_x = 6'd5; size_y = 6'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset during RUN of i=1 (cycle 6), then restart on the first edge after release
        @(negedge clk);
        issue(3, 2, 4, 19);
        repeat (5) @(negedge clk);
        chk("pre_reset_in_run", 64'(x_rd), 64'd1);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rd", 64'({x_rd, y_rd}), 64'd0);
        chk("mid_rst_addr", 64'({x_addr, y_addr}), 64'd0);
        chk("mid_rst_zwe", 64'(z_we), 64'd0);
        zq.delete();
        dq.delete();
        @(negedge clk);
        chk("in_rst_zwe", 64'(z_we), 64'd0);
        rst_a = 1'b0;
        issue(3, 2, 4, 19);
        wait_done();

        // Max size, all-ones samples
        for (int i = 0; i < 32; i++) begin x_mem[i] = 16'hFFFF; y_mem[i] = 16'hFFFF; end
        for (int i = 0; i < 63; i++) exp_z[i] = ACC_W'((i < 32) ? (i + 1) : (63 - i)) * 37'h0FFFE0001;
        @(negedge clk);
        issue(32, 32, 63, 1214);
        wait_done();
        chk("max_z31_const", 64'(exp_z[31]), 64'h1F_FFC0_0020);

        repeat (2) @(negedge clk);
        chk("queues_drained", 64'(zq.size() + dq.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
